// File: rtl/aes256_round_ctrl.sv
// ----------------------------------------------------------------------------
// aes256_round_ctrl
//
// Iterative AES round sequencer. Holds the 128-bit state register and the round
// counter, accepts one plaintext block over a valid/ready handshake, applies the
// initial AddRoundKey itself and then steps an external combinational round
// datapath once per cycle until the ciphertext sits in the state register.
//
// State layout: byte n of the block lives at [127-8n -: 8], column-major, which
// is the layout the round datapath expects.
//
// Parameters
//   NR  number of rounds (10, 12 or 14); the round counter is 4 bits wide
//   DW  block width, 128 only
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   abort       (AES_ABORT_EN only) drop the block in flight and return to IDLE
//   in_valid    plaintext offered
//   in_ready    controller is idle and will take a block
//   in_data     plaintext block
//   out_valid   ciphertext held on out_data
//   out_ready   consumer takes the ciphertext
//   out_data    state register
//   key_idx     round-key index requested this cycle
//   rk          round key for key_idx (combinational from the key store)
//   rnd_state   state handed to the round datapath (state register)
//   rnd_final   current round is the last one (datapath skips MixColumns)
//   rnd_result  round datapath output
//   busy        block in flight or ciphertext waiting
//
// Build option
//   AES_ABORT_EN  when defined, adds the abort input. Without it, a started block
//                 always runs to completion unless rst is asserted.
// ----------------------------------------------------------------------------
module aes256_round_ctrl #(
  parameter int NR = 14,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
`ifdef AES_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    key_idx,
  input  logic [DW-1:0] rk,
  output logic [DW-1:0] rnd_state,
  output logic          rnd_final,
  input  logic [DW-1:0] rnd_result,
  output logic          busy
);

  if (!(NR == 10 || NR == 12 || NR == 14) || DW != 128) begin : g_param_check
    $error("aes256_round_ctrl: NR must be 10/12/14 and DW must be 128");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_data;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_rnd_final;
  logic [3:0]    r_key_idx;

  logic          w_abort;
  logic [3:0]    w_cnt_inc;

`ifdef AES_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_cnt_inc = r_cnt + 4'd1;

  // All status outputs are registered alongside the FSM so that nothing on the
  // output side depends combinationally on in_valid/out_ready. Each transition
  // therefore loads the output values that belong to the state being entered.
  always_ff @(posedge clk) begin
    // Abort only acts on a block in flight; in IDLE it is ignored. rst wins
    // simply because it shares this branch.
    if (rst || (w_abort && (r_state != S_IDLE))) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_data      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rnd_final <= 1'b0;
      r_key_idx   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Initial AddRoundKey uses rk for key_idx=0, presented while idle.
            r_state     <= S_ROUND;
            r_cnt       <= 4'd1;
            r_data      <= in_data ^ rk;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_key_idx   <= 4'd1;
            r_rnd_final <= 1'b0;
          end
        end
        S_ROUND: begin
          r_data <= rnd_result;
          if (r_cnt == NR_L) begin
            // Counter parks at NR while the ciphertext waits in DONE.
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_key_idx   <= 4'd0;
            r_rnd_final <= 1'b0;
          end else begin
            r_cnt       <= w_cnt_inc;
            r_key_idx   <= w_cnt_inc;
            r_rnd_final <= (w_cnt_inc == NR_L);
          end
        end
        S_DONE: begin
          // No same-cycle reload: a new block is only taken from IDLE.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign key_idx   = r_key_idx;
  assign rnd_final = r_rnd_final;
  assign out_data  = r_data;
  assign rnd_state = r_data;

endmodule

// File: tb/tb_aes256_round_ctrl.sv
module tb_aes256_round_ctrl;

  localparam int NR = 14;
  typedef logic [14:0][127:0] rks_t;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, rnd_final, busy;
  logic [127:0] in_data, out_data, rk, rnd_state, rnd_result;
  logic [3:0]   key_idx;
  logic [255:0] key = '0;
  rks_t         rks_cur;
`ifdef AES_ABORT_EN
  logic         abort;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes256_round_ctrl #(.NR(NR), .DW(128)) dut (
    .clk(clk),
    .rst(rst),
`ifdef AES_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .key_idx(key_idx),
    .rk(rk),
    .rnd_state(rnd_state),
    .rnd_final(rnd_final),
    .rnd_result(rnd_result),
    .busy(busy)
  );

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: inverse in GF(2^8) (x^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] r;
    for (int n = 0; n < 16; n++) a[n] = sbox(s[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[4*c+w] = a[4*((c+w)%4)+w];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        c0 = t[4*c]; c1 = t[4*c+1]; c2 = t[4*c+2]; c3 = t[4*c+3];
        t[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        t[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        t[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        t[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = t[n];
    return r ^ k;
  endfunction

  function automatic rks_t expand(input logic [255:0] kk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rks_t        r;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = kk[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int k = 0; k < 15; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  // State after the initial AddRoundKey and n full rounds.
  function automatic logic [127:0] aes_partial(input logic [127:0] pt, input logic [255:0] kk,
                                               input int n);
    rks_t         rr;
    logic [127:0] s;
    rr = expand(kk);
    s  = pt ^ rr[0];
    for (int i = 1; i <= n; i++) s = aes_round(s, rr[i], i == NR);
    return s;
  endfunction

  // ---------------- environment: key store + round datapath ----------------
  always_comb rks_cur = expand(key);
  assign rk         = (key_idx <= 4'd14) ? rks_cur[key_idx] : '0;
  assign rnd_result = aes_round(rnd_state, rk, rnd_final);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // m_age counts cycles since the accepting edge: 1..NR = rounds, NR+1 = waiting.
  bit           m_on = 1'b0;
  bit           m_busy = 1'b0;
  int           m_age = 0;
  logic [127:0] m_pt, m_last, e_data;
  logic [255:0] m_key;
  logic [127:0] got_q [$];
  int           acc_q [$];

  always @(negedge clk) begin
    if (m_on) begin
      e_data = m_busy ? aes_partial(m_pt, m_key, m_age - 1) : m_last;
      chk("in_ready",  128'(in_ready),  128'(!m_busy));
      chk("busy",      128'(busy),      128'(m_busy));
      chk("out_valid", 128'(out_valid), 128'(m_busy && m_age == NR + 1));
      chk("key_idx",   128'(key_idx),   128'((m_busy && m_age <= NR) ? m_age : 0));
      chk("rnd_final", 128'(rnd_final), 128'(m_busy && m_age == NR));
      chk("out_data",  out_data,  e_data);
      chk("rnd_state", rnd_state, e_data);
    end
    if (rst) begin
      m_on = 1'b1; m_busy = 1'b0; m_age = 0; m_last = '0;
    end
`ifdef AES_ABORT_EN
    else if (m_busy && abort) begin
      m_busy = 1'b0; m_age = 0; m_last = '0;
    end
`endif
    else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1; m_age = 1; m_pt = in_data; m_key = key;
        acc_q.push_back(cyc);
      end
    end else if (m_age <= NR) begin
      m_age++;
    end else if (out_ready) begin
      got_q.push_back(out_data);
      m_last = aes_partial(m_pt, m_key, NR);
      m_busy = 1'b0; m_age = 0;
    end
  end

  task automatic wait_ov(input int max);
    int n;
    n = 0;
    while (!out_valid && n < max) begin tick(); n++; end
    chk("out_valid_wait", 128'(out_valid), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] pts [4];
    logic [127:0] pt2;
    int           lat, n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif

    // model pins from FIPS-197
    chk("pin_sbox53", 128'(sbox(8'h53)), 128'(8'hed));
    chk("pin_round1_start", aes_partial(FIPS_PT, FIPS_KEY, 0),
        128'h00102030405060708090a0b0c0d0e0f0);
    chk("pin_fips_ct", aes_partial(FIPS_PT, FIPS_KEY, NR), FIPS_CT);

    do_reset();
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_out_data",  out_data,        128'h0);
    chk("rst_key_idx",   128'(key_idx),   128'(0));
    chk("rst_rnd_final", 128'(rnd_final), 128'(0));

    // 1 + 5: FIPS vector, latency, key_idx trace
    key = FIPS_KEY; in_data = FIPS_PT; in_valid = 1'b1; out_ready = 1'b1;
    chk("t5_kidx_accept", 128'(key_idx), 128'(0));
    tick();
    in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    for (int i = 1; i <= NR; i++) begin
      chk("t5_kidx", 128'(key_idx), 128'(i));
      chk("t5_final", 128'(rnd_final), 128'(i == NR));
      if (i < NR) begin tick(); lat++; end
    end
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("t1_latency", 128'(lat), 128'(15));
    chk("t1_ct", out_data, FIPS_CT);
    tick();
    chk("t1_ready_after", 128'(in_ready), 128'(1));

    // 2: consumer stall in DONE
    in_data = FIPS_PT; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_ov(40);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    in_data = pt2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t2_ov", 128'(out_valid), 128'(1));
      chk("t2_ct", out_data, FIPS_CT);
      chk("t2_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t2_idle_ready", 128'(in_ready), 128'(1));
    tick();
    chk("t2_second_busy", 128'(busy), 128'(1));
    in_valid = 1'b0;
    wait_ov(40);
    chk("t2_second_ct", out_data, aes_partial(pt2, FIPS_KEY, NR));
    tick();

    // 3: back-to-back with in_valid held high
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    acc_q.delete(); got_q.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      pts[b] = {$urandom, $urandom, $urandom, $urandom};
      n = 0;
      while (!in_ready && n < 64) begin tick(); n++; end
      in_data = pts[b];
      tick();
    end
    in_valid = 1'b0;
    wait_ov(40);
    tick(); tick();
    chk("t3_n_accept", 128'(acc_q.size()), 128'(4));
    chk("t3_n_out", 128'(got_q.size()), 128'(4));
    for (int b = 0; b < 4; b++) begin
      if (b > 0 && b < acc_q.size()) chk("t3_spacing", 128'(acc_q[b] - acc_q[b-1]), 128'(16));
      if (b < got_q.size()) chk("t3_ct", got_q[b], aes_partial(pts[b], key, NR));
    end

    // 4: reset in the middle of a block
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    in_data = pt2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (key_idx != 4'd7 && n < 30) begin tick(); n++; end
    chk("t4_at7", 128'(key_idx), 128'(7));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_in_ready", 128'(in_ready), 128'(1));
    chk("t4_busy", 128'(busy), 128'(0));
    chk("t4_out_data", out_data, 128'h0);
    in_data = pt2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(40);
    chk("t4_ct", out_data, aes_partial(pt2, key, NR));
    tick();

`ifdef AES_ABORT_EN
    // 6: abort mid-block, then abort while idle
    in_data = pt2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (key_idx != 4'd3 && n < 30) begin tick(); n++; end
    chk("t6_at3", 128'(key_idx), 128'(3));
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_in_ready", 128'(in_ready), 128'(1));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_out_data", out_data, 128'h0);
    for (int i = 0; i < 20; i++) begin
      chk("t6_no_ov", 128'(out_valid), 128'(0));
      tick();
    end
    abort = 1'b1; tick(); tick(); abort = 1'b0;
    chk("t6_idle_abort_ready", 128'(in_ready), 128'(1));
    chk("t6_idle_abort_data", out_data, 128'h0);
`endif

    // random traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      if (!m_busy && ($urandom % 4 == 0))
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 2) != 0;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      rst       = ($urandom % 300) == 0;
`ifdef AES_ABORT_EN
      abort     = ($urandom % 100) == 0;
`endif
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef AES_ABORT_EN
    abort = 1'b0;
`endif
    repeat (40) tick();
    chk("drain_idle", 128'(in_ready), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
